// File: rtl/hazard_unit.sv
// Pipeline hazard unit for a 5-stage RISC-V core: operand forwarding, load-use and
// memory-wait stalls, branch flushes and saturating stall/flush counters.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic [1:0]  ResultSrcD,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    logic [4:0]  r_rs1E, r_rs2E, r_rdE, r_rdM, r_rdW;
    logic        r_regWriteE, r_regWriteM, r_regWriteW;
    logic [1:0]  r_resultSrcE;
    logic        r_pcPend;
    logic [15:0] r_stallCnt, r_flushCnt;

    logic w_memWait, w_lwStall, w_branch, w_stallF, w_flushE;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wm, input logic [4:0] rdm,
                                           input logic       ww, input logic [4:0] rdw);
        if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
        else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        else                                     return 2'b00;
    endfunction

    assign w_memWait = MemReqM & ~MemReadyM;
    assign w_lwStall = (r_resultSrcE == 2'b01) && (r_rdE != 5'd0) &&
                       ((r_rdE == Rs1D) || (r_rdE == Rs2D));
    // A branch seen while the pipe is frozen is remembered, since the E stage that
    // raised it is held and must still be squashed once the wait ends.
    assign w_branch  = PCSrcE | r_pcPend;
    assign w_stallF  = w_lwStall | w_memWait;
    assign w_flushE  = (w_lwStall | w_branch) & ~w_memWait;

    assign ForwardAE  = fwd_sel(r_rs1E, r_regWriteM, r_rdM, r_regWriteW, r_rdW);
    assign ForwardBE  = fwd_sel(r_rs2E, r_regWriteM, r_rdM, r_regWriteW, r_rdW);
    assign StallF     = w_stallF;
    assign StallD     = w_stallF;
    assign StallE     = w_memWait;
    assign StallM     = w_memWait;
    assign FlushW     = w_memWait;
    assign FlushD     = w_branch & ~w_memWait;
    assign FlushE     = w_flushE;
    assign StallCount = r_stallCnt;
    assign FlushCount = r_flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs1E       <= '0;
            r_rs2E       <= '0;
            r_rdE        <= '0;
            r_regWriteE  <= 1'b0;
            r_resultSrcE <= '0;
            r_rdM        <= '0;
            r_regWriteM  <= 1'b0;
            r_rdW        <= '0;
            r_regWriteW  <= 1'b0;
            r_pcPend     <= 1'b0;
            r_stallCnt   <= '0;
            r_flushCnt   <= '0;
        end else begin
            if (w_memWait) begin
                r_rdW       <= '0;
                r_regWriteW <= 1'b0;
                if (PCSrcE) r_pcPend <= 1'b1;
            end else begin
                r_rdW        <= r_rdM;
                r_regWriteW  <= r_regWriteM;
                r_rdM        <= r_rdE;
                r_regWriteM  <= r_regWriteE;
                r_rs1E       <= w_flushE ? 5'd0 : Rs1D;
                r_rs2E       <= w_flushE ? 5'd0 : Rs2D;
                r_rdE        <= w_flushE ? 5'd0 : RdD;
                r_regWriteE  <= w_flushE ? 1'b0 : RegWriteD;
                r_resultSrcE <= w_flushE ? 2'b00 : ResultSrcD;
                r_pcPend     <= 1'b0;
            end
            if (w_stallF && r_stallCnt != 16'hFFFF) r_stallCnt <= r_stallCnt + 16'd1;
            if (w_flushE && r_flushCnt != 16'hFFFF) r_flushCnt <= r_flushCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scenario bench for hazard_unit: expected outputs are queued as each cycle is driven
// and compared when the cycle's outputs settle.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [15:0] StallCount, FlushCount;

    int n_assert = 0;
    int n_fail   = 0;

    // {FA, FB, SF, SD, SE, SM, FD, FE, FW}
    localparam logic [10:0] V0   = 11'b00_00_0000_000;
    localparam logic [10:0] S_LW = 11'b00_00_1100_010;
    localparam logic [10:0] S_MW = 11'b00_00_1111_001;
    localparam logic [10:0] S_BR = 11'b00_00_0000_110;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        rw;
        logic [1:0]  rsrc;
        logic        pc, mreq, mrdy;
        logic [10:0] v;
        logic [15:0] sc, fc;
    } vec_t;

    typedef struct {
        logic [10:0] v;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t sb[$];

    wire [10:0] obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic rw, logic [1:0] rsrc, logic pc, logic mreq, logic mrdy,
                                logic [10:0] v, logic [15:0] sc, logic [15:0] fc);
        vec_t t;
        t.rst = rst; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.rsrc = rsrc;
        t.pc = pc; t.mreq = mreq; t.mrdy = mrdy; t.v = v; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, wait for outputs to settle.
    task automatic step(input vec_t t);
        exp_t e;
        reset = t.rst; Rs1D = t.rs1; Rs2D = t.rs2; RdD = t.rd; RegWriteD = t.rw;
        ResultSrcD = t.rsrc; PCSrcE = t.pc; MemReqM = t.mreq; MemReadyM = t.mrdy;
        e.v = t.v; e.sc = t.sc; e.fc = t.fc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = '0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 1, 2, 5, 1, 0, 0, 0, 0, V0, 0, 0));              // add x5
        t.push_back(mk(0, 5, 3, 6, 1, 0, 0, 0, 0, V0, 0, 0));              // consumer of x5
        t.push_back(mk(0, 5, 9, 10, 1, 0, 0, 0, 0, 11'b10_00_0000_000, 0, 0));
        t.push_back(mk(0, 10, 10, 0, 0, 0, 0, 0, 0, 11'b01_00_0000_000, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b10_10_0000_000, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL fwd[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 1, 2, 7, 1, 1, 0, 0, 0, V0, 0, 0));              // lw x7
        t.push_back(mk(0, 3, 7, 8, 1, 0, 0, 0, 0, S_LW, 0, 0));            // use x7
        t.push_back(mk(0, 3, 7, 8, 1, 0, 0, 0, 0, V0, 1, 1));              // held, bubble in E
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_01_0000_000, 1, 1));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 1, 2, 3, 1, 0, 0, 0, 0, V0, 0, 0));
        t.push_back(mk(0, 4, 5, 6, 1, 0, 1, 0, 0, S_BR, 0, 0));            // taken branch
        t.push_back(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, V0, 0, 1));              // reads flushed x6
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 0, 1));              // x6 was squashed
        // load-use and branch together
        t.push_back(mk(0, 1, 2, 7, 1, 1, 0, 0, 0, V0, 0, 1));
        t.push_back(mk(0, 0, 7, 8, 1, 0, 1, 0, 0, 11'b00_00_1100_110, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 1, 2));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 1, 2, 3, 1, 0, 0, 0, 0, V0, 0, 0));
        t.push_back(mk(0, 3, 0, 4, 1, 0, 0, 1, 0, S_MW, 0, 0));
        t.push_back(mk(0, 3, 0, 4, 1, 0, 1, 1, 0, S_MW, 1, 0));            // branch during wait
        t.push_back(mk(0, 3, 0, 4, 1, 0, 0, 1, 0, S_MW, 2, 0));
        t.push_back(mk(0, 3, 0, 4, 1, 0, 0, 1, 1, S_BR, 3, 0));            // wait over
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 3, 1));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, V0, 0, 0));              // load to x0
        t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, V0, 0, 0));              // reads x0
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, V0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL x0[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    // Load held in E under a long memory wait stalls every cycle.
    task automatic test_saturation();
        vec_t s;
        exp_t e;
        do_reset();
        step(mk(0, 1, 2, 7, 1, 1, 0, 0, 0, V0, 0, 0));
        e = sb.pop_front();
        @(posedge clk); #1;
        for (int i = 0; i < 70000; i++) begin
            s = mk(0, 0, 7, 8, 1, 0, 0, 1, 0, S_MW, (i > 65535) ? 16'hFFFF : 16'(i), 0);
            reset = s.rst; Rs1D = s.rs1; Rs2D = s.rs2; RdD = s.rd; RegWriteD = s.rw;
            ResultSrcD = s.rsrc; PCSrcE = s.pc; MemReqM = s.mreq; MemReadyM = s.mrdy;
            if (i == 0 || i == 65534 || i == 65535 || i == 69999) begin
                e.v = s.v; e.sc = s.sc; e.fc = s.fc;
                sb.push_back(e);
                @(negedge clk);
                e = sb.pop_front();
                n_assert++;
                if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                    n_fail++;
                    $display("FAIL saturate[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                             i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 1, 2, 5, 1, 0, 0, 0, 0, V0, 0, 0));
        t.push_back(mk(0, 5, 0, 6, 1, 0, 0, 0, 0, V0, 0, 0));
        t.push_back(mk(0, 5, 0, 6, 1, 0, 0, 1, 0, 11'b10_00_1111_001, 0, 0));
        t.push_back(mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 11'b10_00_1111_001, 1, 0));
        t.push_back(mk(0, 5, 0, 6, 1, 0, 0, 0, 0, V0, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            e = sb.pop_front();
            n_assert++;
            if (obs !== e.v || StallCount !== e.sc || FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL reset_mid_wait[%0d]: got %b sc=%h fc=%h, want %b sc=%h fc=%h",
                         i, obs, StallCount, FlushCount, e.v, e.sc, e.fc);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_x0();
        test_reset_mid_wait();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
